// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared types and constants for the instruction fetch stage
package instruction_fetch_pkg;

  localparam int XLEN              = 32;
  localparam int IFETCH_FIFO_DEPTH = 2;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  typedef enum logic {
    FETCH_RUN   = 1'b0,
    FETCH_FLUSH = 1'b1
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - parameterised synchronous FIFO with flush, used for the fetch buffer and PC tag queue
module fetch_fifo
  import instruction_fetch_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_entry_t,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  T                 data_i,
  input  logic             pop_i,
  output T                 data_o,
  output logic [CNT_W-1:0] count_o
);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push = push_i && (cnt < CNT_W'(DEPTH));
  assign do_pop  = pop_i && (cnt != '0);
  assign count_o = cnt;

  // Pointer and occupancy bookkeeping; a flush wins over any same-cycle push or pop.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; contents are only meaningful while counted, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem[wr_ptr] <= data_i;
  end

  // Head is presented combinationally and forced to zero while empty.
  always_comb begin
    data_o = '0;
    if (cnt != '0) data_o = mem[rd_ptr];
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage with credit-based issue, redirect flush and optional IFETCH_ALIGN_CHECK_EN
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = IFETCH_FIFO_DEPTH,
  parameter int MAX_OUTST  = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            pc_enable_o,
  input  logic            redirect_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i,
  output logic            fetch_fault_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OST_W = $clog2(MAX_OUTST) + 1;
  localparam int SUM_W = CNT_W + 1;

  fetch_state_e     state_q;
  fetch_state_e     state_d;
  logic [OST_W-1:0] kill_q;
  logic [OST_W-1:0] kill_d;
  logic [CNT_W-1:0] fifo_cnt;
  logic [OST_W-1:0] outst_cnt;
  logic [OST_W-1:0] outst_next;
  logic [XLEN-1:0]  tag_head;
  fetch_entry_t     buf_head;
  fetch_entry_t     buf_wdata;
  logic             credit_ok;
  logic             align_ok;
  logic             issue;
  logic             grant;
  logic             resp;
  logic             resp_keep;
  logic             buf_pop;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic fault_q;
  logic fault_d;

  assign align_ok = !fault_q && !is_misaligned(pc_i);
  assign fault_d  = redirect_i ? 1'b0
                  : (fault_q || ((state_q == FETCH_RUN) && is_misaligned(pc_i)));

  // Sticky misalignment fault, cleared only by a redirect or reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end

  assign fetch_fault_o = fault_q && !rst_i;
`else
  assign align_ok      = 1'b1;
  assign fetch_fault_o = 1'b0;
`endif

  // Every issued request reserves a buffer slot, so responses never need backpressure.
  assign credit_ok = ({1'b0, fifo_cnt} + SUM_W'(outst_cnt)) < SUM_W'(FIFO_DEPTH);
  assign issue     = !rst_i && (state_q == FETCH_RUN) && !redirect_i && credit_ok
                     && (outst_cnt < OST_W'(MAX_OUTST)) && align_ok;
  assign grant     = issue && imem_gnt_i;

  // Responses with nothing outstanding belong to pre-reset requests and are ignored.
  assign resp      = !rst_i && imem_rvalid_i && (outst_cnt != '0);
  assign resp_keep = resp && (kill_q == '0) && !redirect_i;
  assign buf_pop   = instr_valid_o && instr_ready_i && !redirect_i;

  assign outst_next = outst_cnt + OST_W'(grant) - OST_W'(resp);

  assign buf_wdata = '{instr: imem_rdata_i, pc: tag_head};

  assign imem_req_o    = issue;
  assign imem_addr_o   = rst_i ? '0 : pc_i;
  assign pc_enable_o   = !rst_i && (grant || redirect_i);
  assign instr_valid_o = !rst_i && (fifo_cnt != '0);
  assign instr_o       = rst_i ? '0 : buf_head.instr;
  assign instr_pc_o    = rst_i ? '0 : buf_head.pc;

  fetch_fifo #(
    .DEPTH (MAX_OUTST),
    .T     (logic [XLEN-1:0])
  ) u_tag_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (1'b0),
    .push_i  (grant),
    .data_i  (pc_i),
    .pop_i   (resp),
    .data_o  (tag_head),
    .count_o (outst_cnt)
  );

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fetch_entry_t)
  ) u_fetch_buffer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (resp_keep),
    .data_i  (buf_wdata),
    .pop_i   (buf_pop),
    .data_o  (buf_head),
    .count_o (fifo_cnt)
  );

  // State and kill counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FETCH_RUN;
      kill_q  <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

  // Redirect arms the kill counter with what is still in flight; FLUSH drains it.
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    if (redirect_i) begin
      kill_d  = outst_next;
      state_d = (outst_next != '0) ? FETCH_FLUSH : FETCH_RUN;
    end else begin
      if (resp && (kill_q != '0)) kill_d = kill_q - OST_W'(1);
      if ((state_q == FETCH_FLUSH) && (kill_d == '0)) state_d = FETCH_RUN;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [XLEN-1:0] pc_i;
  logic            pc_enable_o;
  logic            redirect_i;
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [XLEN-1:0] imem_rdata_i;
  logic            instr_valid_o;
  logic [XLEN-1:0] instr_o;
  logic [XLEN-1:0] instr_pc_o;
  logic            instr_ready_i;
  logic            fetch_fault_o;

  always #5 clk_i = ~clk_i;

  instruction_fetch #(
    .FIFO_DEPTH (2),
    .MAX_OUTST  (2)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .pc_i          (pc_i),
    .pc_enable_o   (pc_enable_o),
    .redirect_i    (redirect_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i),
    .fetch_fault_o (fetch_fault_o)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] pc_model;
  logic [31:0] target;
  bit          resp_en;
  logic [31:0] pend[$];
  logic        s_req, s_pcen, s_valid, s_fault;
  logic [31:0] s_addr, s_instr, s_ipc;
  logic [31:0] exp_pc;
  int          pops;
  int          grants;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock cycle: memory model drives the response, outputs are sampled mid-cycle,
  // the scoreboard checks pops, then the PC model updates after the edge.
  task automatic tick();
    if (resp_en && pend.size() > 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = instr_of(pend.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
    end
    #1;
    s_req   = imem_req_o;
    s_addr  = imem_addr_o;
    s_pcen  = pc_enable_o;
    s_valid = instr_valid_o;
    s_instr = instr_o;
    s_ipc   = instr_pc_o;
    s_fault = fetch_fault_o;
    check("pc_enable", {31'b0, s_pcen},
          rst_i ? 32'd0 : {31'b0, (s_req & imem_gnt_i) | redirect_i});
    if (s_req) check("req_addr", s_addr, pc_model);
    if (s_req && imem_gnt_i) begin
      pend.push_back(s_addr);
      grants++;
    end
    if (!rst_i && !redirect_i && s_valid && instr_ready_i) begin
      check("pop_pc", s_ipc, exp_pc);
      check("pop_instr", s_instr, instr_of(exp_pc));
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    @(posedge clk_i);
    #1;
    if (rst_i)                pc_model = 32'd0;
    else if (redirect_i)      pc_model = target;
    else if (s_pcen)          pc_model = pc_model + 32'd4;
    pc_i          = pc_model;
    imem_rvalid_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic apply_reset();
    rst_i      = 1'b1;
    redirect_i = 1'b0;
    tick();
    tick();
    rst_i  = 1'b0;
    exp_pc = 32'd0;
    pops   = 0;
    grants = 0;
  endtask

  task automatic run_until_pops(input int n, input int budget);
    int k;
    k = 0;
    while (pops < n && k < budget) begin
      tick();
      k++;
    end
    check("pop_count", pops, n);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_i         = 1'b1;
    pc_model      = 32'd0;
    pc_i          = 32'd0;
    redirect_i    = 1'b0;
    target        = 32'd0;
    imem_gnt_i    = 1'b1;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'd0;
    instr_ready_i = 1'b1;
    resp_en       = 1'b1;
    exp_pc        = 32'd0;
    pops          = 0;
    grants        = 0;
    @(negedge clk_i);

    // Reset state
    apply_reset();
    check("rst_req", {31'b0, s_req}, 32'd0);
    check("rst_valid", {31'b0, s_valid}, 32'd0);
    check("rst_instr", s_instr, 32'd0);
    check("rst_instr_pc", s_ipc, 32'd0);
    check("rst_fault", {31'b0, s_fault}, 32'd0);

    // 1: streaming from PC 0, in-order delivery
    run_until_pops(8, 40);

    // 2: backpressure caps issue at the buffer depth, then drains in order
    apply_reset();
    instr_ready_i = 1'b0;
    repeat (6) tick();
    check("bp_req", {31'b0, s_req}, 32'd0);
    check("bp_valid", {31'b0, s_valid}, 32'd1);
    check("bp_head_pc", s_ipc, 32'd0);
    check("bp_grants", grants, 2);
    instr_ready_i = 1'b1;
    run_until_pops(4, 30);

    // 3: redirect with two requests in flight
    apply_reset();
    resp_en = 1'b0;
    tick();
    tick();
    check("rd_grants", grants, 2);
    redirect_i = 1'b1;
    target     = 32'h0000_0100;
    tick();
    check("rd_req_in_redirect", {31'b0, s_req}, 32'd0);
    check("rd_pcen_in_redirect", {31'b0, s_pcen}, 32'd1);
    redirect_i = 1'b0;
    resp_en    = 1'b1;
    exp_pc     = 32'h0000_0100;
    tick();
    check("rd_flush1_valid", {31'b0, s_valid}, 32'd0);
    check("rd_flush1_req", {31'b0, s_req}, 32'd0);
    tick();
    check("rd_flush2_valid", {31'b0, s_valid}, 32'd0);
    check("rd_flush2_req", {31'b0, s_req}, 32'd0);
    tick();
    check("rd_resume_req", {31'b0, s_req}, 32'd1);
    check("rd_resume_addr", s_addr, 32'h0000_0100);
    run_until_pops(2, 20);

    // 4: redirect together with a response and a decode pop
    apply_reset();
    tick();
    tick();
    redirect_i = 1'b1;
    target     = 32'h0000_0200;
    tick();
    check("rv_valid_at_redirect", {31'b0, s_valid}, 32'd1);
    check("rv_req_at_redirect", {31'b0, s_req}, 32'd0);
    redirect_i = 1'b0;
    exp_pc     = 32'h0000_0200;
    tick();
    check("rv_empty_after", {31'b0, s_valid}, 32'd0);
    check("rv_req_after", {31'b0, s_req}, 32'd1);
    check("rv_addr_after", s_addr, 32'h0000_0200);
    run_until_pops(2, 20);

    // 5: reset mid-stream with responses still pending
    apply_reset();
    resp_en = 1'b0;
    tick();
    tick();
    rst_i   = 1'b1;
    resp_en = 1'b1;
    tick();
    check("mr_req", {31'b0, s_req}, 32'd0);
    check("mr_pcen", {31'b0, s_pcen}, 32'd0);
    check("mr_valid", {31'b0, s_valid}, 32'd0);
    check("mr_instr", s_instr, 32'd0);
    check("mr_instr_pc", s_ipc, 32'd0);
    rst_i  = 1'b0;
    pops   = 0;
    exp_pc = 32'd0;
    tick();
    check("mr_first_req", {31'b0, s_req}, 32'd1);
    check("mr_first_addr", s_addr, 32'd0);
    check("mr_stale_valid", {31'b0, s_valid}, 32'd0);
    run_until_pops(2, 20);

    // 6: redirect to a misaligned target
    apply_reset();
    imem_gnt_i = 1'b0;
    redirect_i = 1'b1;
    target     = 32'h0000_0102;
    tick();
    redirect_i = 1'b0;
    imem_gnt_i = 1'b1;
    tick();
`ifdef IFETCH_ALIGN_CHECK_EN
    check("al_req_blocked", {31'b0, s_req}, 32'd0);
    check("al_fault_not_yet", {31'b0, s_fault}, 32'd0);
    tick();
    check("al_fault_set", {31'b0, s_fault}, 32'd1);
    check("al_req_faulted", {31'b0, s_req}, 32'd0);
    check("al_pcen_faulted", {31'b0, s_pcen}, 32'd0);
    redirect_i = 1'b1;
    target     = 32'h0000_0200;
    tick();
    check("al_fault_sticky", {31'b0, s_fault}, 32'd1);
    check("al_pcen_redirect", {31'b0, s_pcen}, 32'd1);
    redirect_i = 1'b0;
    tick();
    check("al_fault_cleared", {31'b0, s_fault}, 32'd0);
    check("al_resume_req", {31'b0, s_req}, 32'd1);
    check("al_resume_addr", s_addr, 32'h0000_0200);
`else
    check("al_req_unchecked", {31'b0, s_req}, 32'd1);
    check("al_addr_passthru", s_addr, 32'h0000_0102);
    check("al_fault_tied", {31'b0, s_fault}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
